// File: rtl/vlogic_seq_if.sv
// Bundles the issue, register-file read and writeback signals of the vector logic sequencer.
// The sequencer connects through master and the issue stage / register file / writeback side through slave.
interface vlogic_seq_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_CHUNKS = 8
);
  localparam int unsigned CW = $clog2(MAX_CHUNKS);
  localparam int unsigned NW = $clog2(MAX_CHUNKS + 1);

  logic                  issue_valid;
  logic                  issue_ready;
  logic [1:0]            issue_op;
  logic [NW-1:0]         issue_nchunks;
  logic [4:0]            issue_src1;
  logic [4:0]            issue_src2;
  logic [4:0]            issue_dst;

  logic                  rd_en;
  logic [4:0]            rd_addr1;
  logic [4:0]            rd_addr2;
  logic [CW-1:0]         rd_chunk;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic [DATA_WIDTH-1:0] rd_data2;

  logic                  wr_en;
  logic [4:0]            wr_addr;
  logic [CW-1:0]         wr_chunk;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  logic                  busy;
  logic                  done;

  modport master (
    input  issue_valid, issue_op, issue_nchunks, issue_src1, issue_src2, issue_dst,
    input  rd_data1, rd_data2, wr_ready,
    output issue_ready, rd_en, rd_addr1, rd_addr2, rd_chunk,
    output wr_en, wr_addr, wr_chunk, wr_data, busy, done
  );

  modport slave (
    output issue_valid, issue_op, issue_nchunks, issue_src1, issue_src2, issue_dst,
    output rd_data1, rd_data2, wr_ready,
    input  issue_ready, rd_en, rd_addr1, rd_addr2, rd_chunk,
    input  wr_en, wr_addr, wr_chunk, wr_data, busy, done
  );
endinterface

// File: rtl/vlogic_seq.sv
// Sequences one vector bitwise-logic instruction chunk by chunk: read request, one-cycle
// read latency, result into a 2-entry writeback buffer, done pulse when the last chunk leaves.
module vlogic_seq #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_CHUNKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  vlogic_seq_if.master bus
);
  localparam int unsigned CW = $clog2(MAX_CHUNKS);
  localparam int unsigned NW = $clog2(MAX_CHUNKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CW-1:0]         chunk;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                r_state;
  logic [1:0]            r_op;
  logic [4:0]            r_src1;
  logic [4:0]            r_src2;
  logic [4:0]            r_dst;
  logic [NW-1:0]         r_n;
  logic [NW-1:0]         r_rd_cnt;
  logic                  r_inflight;
  logic [CW-1:0]         r_infl_chunk;
  entry_t                r_buf [2];
  logic                  r_head;
  logic [1:0]            r_buf_cnt;

  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic [NW-1:0]         w_n_clip;
  logic [CW-1:0]         w_last_chunk;
  entry_t                w_head;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_n_clip     = (bus.issue_nchunks > NW'(MAX_CHUNKS)) ? NW'(MAX_CHUNKS) : bus.issue_nchunks;
  assign w_last_chunk = CW'(r_n - NW'(1));
  assign w_head       = r_buf[r_head];
  assign w_wr_en      = (r_buf_cnt != 2'd0);
  assign w_pop        = w_wr_en & bus.wr_ready;
  // Occupancy the buffer would reach if everything already requested lands, net of this cycle's pop.
  assign w_occ        = 3'(r_buf_cnt) + 3'(r_inflight) - 3'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.issue_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_n_clip != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_occ < 3'd2) begin
          w_rd_en = 1'b1;
          if (r_rd_cnt == r_n - NW'(1)) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && (w_head.chunk == w_last_chunk)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = bus.rd_data1 & bus.rd_data2;
      2'b01:   w_result = bus.rd_data1 | bus.rd_data2;
      2'b10:   w_result = bus.rd_data1 ^ bus.rd_data2;
      default: w_result = ~(bus.rd_data1 ^ bus.rd_data2);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= '0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_dst        <= '0;
      r_n          <= '0;
      r_rd_cnt     <= '0;
      r_inflight   <= 1'b0;
      r_infl_chunk <= '0;
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
      r_head       <= 1'b0;
      r_buf_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= bus.issue_op;
        r_src1   <= bus.issue_src1;
        r_src2   <= bus.issue_src2;
        r_dst    <= bus.issue_dst;
        r_n      <= w_n_clip;
        r_rd_cnt <= '0;
      end else if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + NW'(1);
      end
      r_inflight <= w_rd_en;
      if (w_rd_en) r_infl_chunk <= r_rd_cnt[CW-1:0];
      // Tail slot is head + count modulo 2.
      if (r_inflight) r_buf[r_head ^ r_buf_cnt[0]] <= '{chunk: r_infl_chunk, data: w_result};
      if (w_pop) r_head <= ~r_head;
      r_buf_cnt <= r_buf_cnt + 2'(r_inflight) - 2'(w_pop);
    end
  end

  assign bus.issue_ready = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.rd_en       = w_rd_en;
  assign bus.rd_addr1    = r_src1;
  assign bus.rd_addr2    = r_src2;
  assign bus.rd_chunk    = r_rd_cnt[CW-1:0];
  assign bus.wr_en       = w_wr_en;
  assign bus.wr_addr     = r_dst;
  assign bus.wr_chunk    = w_head.chunk;
  assign bus.wr_data     = w_head.data;
endmodule
